// File: rtl/sauria_result_checker.sv
// sauria_result_checker: streaming golden-vs-acquired word checker with
// bit-exact or FP-ULP lane compare, saturating error count and first-error capture.
module sauria_result_checker #(
  parameter int DATA_W = 128,
  parameter int LANE_W = 16,
  parameter int EXP_W  = 5,
  parameter int IDX_W  = 32,
  parameter int CNT_W  = 32,
  parameter int TOL_W  = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic                     i_start,
  input  logic [IDX_W-1:0]         i_num_words,
  input  logic                     i_mode,
  input  logic [TOL_W-1:0]         i_tol_ulp,
  input  logic [DATA_W-1:0]        i_exp_data,
  input  logic                     i_exp_valid,
  output logic                     o_exp_ready,
  input  logic [DATA_W-1:0]        i_acq_data,
  input  logic                     i_acq_valid,
  output logic                     o_acq_ready,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [CNT_W-1:0]         o_err_count,
  output logic [IDX_W-1:0]         o_checked,
  output logic                     o_mism_pulse,
  output logic                     o_first_err_vld,
  output logic [IDX_W-1:0]         o_first_err_idx,
  output logic [DATA_W/LANE_W-1:0] o_first_err_lanes
);
  localparam int NL = DATA_W / LANE_W;
  localparam int LW = $clog2(NL + 1);
  localparam int DW = (LANE_W + 2 > TOL_W) ? LANE_W + 2 : TOL_W;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [IDX_W-1:0] rem, s1_idx, s2_idx;
  logic mode, s1_vld, s2_vld, start_ok, hs;
  logic [TOL_W-1:0] tol;
  logic [DATA_W-1:0] s1_exp, s1_acq;
  logic [NL-1:0] mask, s2_mask;
  logic [LANE_W-1:0] le, la;
  logic signed [LANE_W:0] ke, ka;
  logic signed [LANE_W+1:0] d;
  logic [DW-1:0] ad;
  logic [LW-1:0] pop;
  logic [CNT_W+LW-1:0] sum;
  assign start_ok    = i_start & (state == IDLE | state == DONE);
  assign o_exp_ready = state == RUN & rem != '0 & i_acq_valid;
  assign o_acq_ready = state == RUN & rem != '0 & i_exp_valid;
  assign hs          = o_exp_ready & i_exp_valid;
  assign o_busy      = state == RUN | state == DRAIN;
  assign o_done      = state == DONE;
  // DRAIN leaves as soon as S1 is empty: S2 retires on that same edge, so DONE and the final count coincide
  always_comb begin
    state_nx = state;
    if (start_ok) state_nx = (i_num_words == '0) ? DRAIN : RUN;
    else if (state == RUN && hs && rem == IDX_W'(1)) state_nx = DRAIN;
    else if (state == DRAIN && !s1_vld) state_nx = DONE;
  end
  // sign-magnitude lanes mapped to a two's-complement key so +0 and -0 compare equal
  always_comb begin
    mask = '0;
    le = '0;
    la = '0;
    ke = '0;
    ka = '0;
    d = '0;
    ad = '0;
    for (int l = 0; l < NL; l++) begin
      le = s1_exp[l*LANE_W +: LANE_W];
      la = s1_acq[l*LANE_W +: LANE_W];
      ke = le[LANE_W-1] ? -$signed({2'b0, le[LANE_W-2:0]}) : $signed({2'b0, le[LANE_W-2:0]});
      ka = la[LANE_W-1] ? -$signed({2'b0, la[LANE_W-2:0]}) : $signed({2'b0, la[LANE_W-2:0]});
      d = {ke[LANE_W], ke} - {ka[LANE_W], ka};
      ad = DW'(d[LANE_W+1] ? -d : d);
      mask[l] = (!mode || &le[LANE_W-2 -: EXP_W] || &la[LANE_W-2 -: EXP_W]) ? le != la : ad > DW'(tol);
    end
  end
  always_comb begin
    pop = '0;
    for (int l = 0; l < NL; l++) pop = pop + LW'(s2_mask[l]);
    sum = {{LW{1'b0}}, o_err_count} + (CNT_W+LW)'(mode ? pop : LW'(1));
  end
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= IDLE;
      rem <= '0;
      mode <= 1'b0;
      tol <= '0;
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
      s1_exp <= '0;
      s1_acq <= '0;
      s1_idx <= '0;
      s2_idx <= '0;
      s2_mask <= '0;
      o_err_count <= '0;
      o_checked <= '0;
      o_mism_pulse <= 1'b0;
      o_first_err_vld <= 1'b0;
      o_first_err_idx <= '0;
      o_first_err_lanes <= '0;
    end else begin
      state <= state_nx;
      s1_vld <= hs;
      s2_vld <= s1_vld;
      o_mism_pulse <= s2_vld & |s2_mask;
      if (hs) begin
        s1_exp <= i_exp_data;
        s1_acq <= i_acq_data;
        s1_idx <= o_checked;
        o_checked <= o_checked + IDX_W'(1);
        rem <= rem - IDX_W'(1);
      end
      if (s1_vld) begin
        s2_mask <= mask;
        s2_idx <= s1_idx;
      end
      if (start_ok) begin
        rem <= i_num_words;
        mode <= i_mode;
        tol <= i_tol_ulp;
        o_checked <= '0;
        o_err_count <= '0;
        o_first_err_vld <= 1'b0;
        o_first_err_idx <= '0;
        o_first_err_lanes <= '0;
      end else if (s2_vld && s2_mask != '0) begin
        o_err_count <= |sum[CNT_W+LW-1:CNT_W] ? '1 : sum[CNT_W-1:0];
        if (!o_first_err_vld) begin
          o_first_err_vld <= 1'b1;
          o_first_err_idx <= s2_idx;
          o_first_err_lanes <= s2_mask;
        end
      end
    end
  end
endmodule

// File: tb/tb_sauria_result_checker.sv
// tb_sauria_result_checker: directed + randomized runs against an integer-arithmetic reference model;
// a second instance with a 4-bit counter shares the stimulus to exercise saturation.
module tb_sauria_result_checker;
  logic clk = 0, rstn = 1, start = 0, mode = 0, exp_valid = 0, acq_valid = 0;
  logic [31:0] num = 0;
  logic [7:0] tol = 0;
  logic [127:0] exp_data = 0, acq_data = 0;
  logic exp_ready, acq_ready, busy, done, mism, fvld;
  logic [31:0] err, checked, fidx;
  logic [7:0] flanes;
  logic s_exp_ready, s_acq_ready, s_busy, s_done, s_mism, s_fvld;
  logic [3:0] s_err;
  logic [31:0] s_checked, s_fidx;
  logic [7:0] s_flanes;
  int checks = 0, failures = 0;
  logic [127:0] ew [32];
  logic [127:0] aw [32];
  always #5 clk = ~clk;

  sauria_result_checker #(.DATA_W(128), .LANE_W(16), .EXP_W(5), .IDX_W(32), .CNT_W(32), .TOL_W(8)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_start(start), .i_num_words(num), .i_mode(mode), .i_tol_ulp(tol),
    .i_exp_data(exp_data), .i_exp_valid(exp_valid), .o_exp_ready(exp_ready),
    .i_acq_data(acq_data), .i_acq_valid(acq_valid), .o_acq_ready(acq_ready),
    .o_busy(busy), .o_done(done), .o_err_count(err), .o_checked(checked), .o_mism_pulse(mism),
    .o_first_err_vld(fvld), .o_first_err_idx(fidx), .o_first_err_lanes(flanes));

  sauria_result_checker #(.DATA_W(128), .LANE_W(16), .EXP_W(5), .IDX_W(32), .CNT_W(4), .TOL_W(8)) dut_sat (
    .i_clk(clk), .i_rstn(rstn), .i_start(start), .i_num_words(num), .i_mode(mode), .i_tol_ulp(tol),
    .i_exp_data(exp_data), .i_exp_valid(exp_valid), .o_exp_ready(s_exp_ready),
    .i_acq_data(acq_data), .i_acq_valid(acq_valid), .o_acq_ready(s_acq_ready),
    .o_busy(s_busy), .o_done(s_done), .o_err_count(s_err), .o_checked(s_checked), .o_mism_pulse(s_mism),
    .o_first_err_vld(s_fvld), .o_first_err_idx(s_fidx), .o_first_err_lanes(s_flanes));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s got=%0h expected=%0h", tag, got, want);
    end
  endtask

  // lanes as plain integers: sign-magnitude to signed value, then absolute distance
  function automatic logic [7:0] ref_mask(input bit m, input int t, input logic [127:0] e, input logic [127:0] a);
    logic [7:0] r = '0;
    for (int l = 0; l < 8; l++) begin
      int ev = int'(e[l*16 +: 16]);
      int av = int'(a[l*16 +: 16]);
      int ke = (ev >= 32768) ? -(ev - 32768) : ev;
      int ka = (av >= 32768) ? -(av - 32768) : av;
      int dd = (ke > ka) ? ke - ka : ka - ke;
      bit special = ((ev >> 10) & 31) == 31 || ((av >> 10) & 31) == 31;
      r[l] = (!m || special) ? (ev != av) : (dd > t);
    end
    return r;
  endfunction

  task automatic run(input string tag, input int n, input bit m, input int t, input bit gaps);
    int ei = 0, ecnt = 0, last_hs = 0, pulses = 0, exp_cnt = 0, exp_pulses = 0, exp_idx = 0;
    logic [7:0] exp_lanes = 0, mk;
    bit exp_vld = 0, hs, join_bad = 0;
    for (int w = 0; w < n; w++) begin
      mk = ref_mask(m, t, ew[w], aw[w]);
      if (mk != 0) begin
        exp_pulses++;
        exp_cnt += m ? $countones(mk) : 1;
        if (!exp_vld) begin
          exp_vld = 1;
          exp_idx = w;
          exp_lanes = mk;
        end
      end
    end
    @(negedge clk);
    start = 1; num = n; mode = m; tol = t;
    @(negedge clk);
    start = 0; num = $urandom; mode = 1'($urandom); tol = 8'($urandom);
    chk({tag, ".busy"}, busy, 1);
    chk({tag, ".not_done"}, done, 0);
    forever begin
      exp_valid = ei < n && (!gaps || $urandom_range(0, 3) != 0);
      acq_valid = ei < n && (!gaps || $urandom_range(0, 3) != 0);
      exp_data = ei < n ? ew[ei] : '0;
      acq_data = ei < n ? aw[ei] : '0;
      #1 hs = exp_valid && exp_ready;
      if (hs != (acq_valid && acq_ready)) join_bad = 1;
      @(posedge clk);
      ecnt++;
      if (hs) begin
        ei++;
        last_hs = ecnt;
      end
      @(negedge clk);
      pulses += int'(mism);
      if (done || ecnt > 400) break;
    end
    exp_valid = 0; acq_valid = 0;
    chk({tag, ".done"}, done, 1);
    chk({tag, ".join"}, join_bad, 0);
    chk({tag, ".consumed"}, ei, n);
    chk({tag, ".checked"}, checked, n);
    chk({tag, ".count"}, err, exp_cnt);
    chk({tag, ".sat_count"}, s_err, exp_cnt > 15 ? 15 : exp_cnt);
    chk({tag, ".first_vld"}, fvld, exp_vld);
    chk({tag, ".first_idx"}, fidx, exp_idx);
    chk({tag, ".first_lanes"}, flanes, exp_lanes);
    chk({tag, ".pulses"}, pulses, exp_pulses);
    chk({tag, ".latency"}, n > 0 ? ecnt == last_hs + 2 : ecnt <= 2, 1);
    exp_valid = 1; acq_valid = 1;
    #1 chk({tag, ".ready_after_done"}, {exp_ready, acq_ready}, 0);
    repeat (3) @(negedge clk);
    chk({tag, ".checked_held"}, checked, n);
    chk({tag, ".done_held"}, done, 1);
    exp_valid = 0; acq_valid = 0;
  endtask

  initial begin
    logic [15:0] b, q;
    int r;
    #2 rstn = 0;
    #1 chk("reset.outputs", {busy, done, mism, fvld, exp_ready, acq_ready}, 0);
    chk("reset.count", {err, checked, fidx, flanes}, 0);
    repeat (2) @(negedge clk);
    rstn = 1;

    for (int w = 0; w < 4; w++) begin ew[w] = {8{16'h1111}}; aw[w] = ew[w]; end
    run("ident", 4, 0, 0, 0);

    aw[2][15:0] = 16'h2222;
    aw[2][95:80] = 16'h3333;
    run("lanes0_5", 4, 0, 0, 0);

    ew[0] = {{4{16'h1234}}, 16'h7C00, 16'h0000, 16'h3C00, 16'h3C00};
    aw[0] = {{4{16'h1234}}, 16'h7BFF, 16'h8000, 16'h3C03, 16'h3C02};
    run("fp_tol2", 1, 1, 2, 0);

    run("num0", 0, 0, 0, 0);

    for (int w = 0; w < 16; w++) begin
      ew[w] = {$urandom, $urandom, $urandom, $urandom};
      aw[w] = $urandom_range(0, 2) == 0 ? ew[w] ^ (128'(1) << $urandom_range(0, 127)) : ew[w];
    end
    run("rand_m0", 16, 0, 0, 1);

    for (int w = 0; w < 16; w++)
      for (int l = 0; l < 8; l++) begin
        b = 16'($urandom);
        if (b[14:10] == 5'h1f && $urandom_range(0, 3) != 0) b[14] = 1'b0;
        r = $urandom_range(0, 4);
        q = r == 0 ? b : r == 1 ? b + 16'($urandom_range(0, 6)) - 16'd3 : r == 2 ? 16'($urandom) :
            r == 3 ? {~b[15], b[14:0]} : 16'h8000;
        if (r == 4) b = 16'h0000;
        ew[w][l*16 +: 16] = b;
        aw[w][l*16 +: 16] = q;
      end
    run("rand_m1", 16, 1, $urandom_range(0, 3), 1);

    @(negedge clk);
    start = 1; num = 16; mode = 0;
    @(negedge clk);
    start = 0; exp_valid = 1; acq_valid = 1;
    exp_data = {4{32'hA5A5_5A5A}}; acq_data = ~exp_data;
    repeat (6) @(negedge clk);
    chk("midrun.busy", busy, 1);
    chk("midrun.counting", err != 0, 1);
    #2 rstn = 0;
    #1 chk("rst_mid.flags", {busy, done, mism, fvld, exp_ready, acq_ready}, 0);
    chk("rst_mid.count", err, 0);
    chk("rst_mid.checked", checked, 0);
    chk("rst_mid.first", {fidx, flanes}, 0);
    chk("rst_mid.sat", s_err, 0);
    exp_valid = 0; acq_valid = 0;
    @(negedge clk);
    rstn = 1;

    ew[0] = {8{16'h4242}}; aw[0] = ew[0]; aw[0][127:112] = 16'h0042;
    run("restart1", 1, 0, 0, 0);

    for (int w = 0; w < 3; w++) begin ew[w] = {8{16'h3C00}}; aw[w] = {8{16'h4000}}; end
    run("saturate", 3, 1, 2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sauria_result_checker.md
Name: sauria_result_checker

Overview:
- Synthesizable streaming checker that compares acquired output words against golden words, lane by lane, in hardware.
- Generalises the bench-side DRAM gold check:
  - parametrised word width and lane width;
  - two compare modes: bit-exact, or FP with a ULP tolerance;
  - running error count, first-mismatch capture and completion flag.
- Sits between the DMA/DRAM read path and the test controller, so FPGA and emulation runs self-check without a simulator.

Parameters:
- DATA_W, 128, word width in bits; must be a multiple of LANE_W.
- LANE_W, 16, lane width (FP mode: sign + EXP_W + mantissa).
- EXP_W, 5, exponent field width used in FP mode.
- IDX_W, 32, width of word-count and word-index fields.
- CNT_W, 32, error counter width.
- TOL_W, 8, width of the ULP tolerance input.

Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  asynchronous active-low reset.
- i_start  in  1  start pulse; sampled only in IDLE or DONE.
- i_num_words  in  IDX_W  number of word pairs to check; latched on start.
- i_mode  in  1  0 = bit-exact per word; 1 = FP tolerance per lane. Latched on start.
- i_tol_ulp  in  TOL_W  maximum allowed |difference| in mode 1. Latched on start.
- i_exp_data  in  DATA_W  golden word.
- i_exp_valid  in  1  golden word valid.
- o_exp_ready  out  1  golden word accepted.
- i_acq_data  in  DATA_W  acquired word.
- i_acq_valid  in  1  acquired word valid.
- o_acq_ready  out  1  acquired word accepted.
- o_busy  out  1  high in RUN and DRAIN.
- o_done  out  1  high in DONE.
- o_err_count  out  CNT_W  accumulated errors.
- o_checked  out  IDX_W  word pairs consumed.
- o_mism_pulse  out  1  one-cycle pulse per mismatching word.
- o_first_err_vld  out  1  first mismatch has been captured.
- o_first_err_idx  out  IDX_W  word index of the first mismatch.
- o_first_err_lanes  out  DATA_W/LANE_W  failing-lane mask of the first mismatch.

Behaviour:
- Reset:
  - all outputs 0; FSM to IDLE; pipeline valids cleared.
  - A reset mid-run aborts the run; no partial result is retained.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE + i_start:
    - latch num/mode/tol; clear count, checked and first-error fields;
    - go to RUN, or to DRAIN if num = 0.
  - RUN: when remaining reaches 0 after a handshake, go to DRAIN.
  - DRAIN: wait until both pipeline stages are empty, then go to DONE.
  - DONE: hold all results until the next i_start.
  - i_start in RUN or DRAIN is ignored.
- Join handshake:
  - o_exp_ready = RUN & remaining≠0 & i_acq_valid.
  - o_acq_ready = RUN & remaining≠0 & i_exp_valid.
  - Transfer occurs when both valids are high in that state; both streams are consumed in the same cycle.
  - Readies never depend on the port's own valid.
- Pipeline:
  - S1: register the pair and its index (= o_checked before increment); o_checked increments at the handshake.
  - S2: per-lane compare, registered lane mask.
  - S3: update count, pulse and first-error fields.
  - Results are visible 2 cycles after the handshake. Throughput is 1 pair/cycle.
- Mode 0:
  - Word error if any lane differs.
  - Lane mask marks the differing lanes.
  - Count += 1 per failing word.
- Mode 1, per lane:
  - Magnitude m = bits[LANE_W-2:0]; signed key s = sign ? -m : m, width LANE_W+1 (so +0 and -0 are equal).
  - Lane fails if |s_exp − s_acq| > tol.
  - If either lane has an all-ones exponent (Inf/NaN), the lane fails unless the bit patterns are identical.
  - Count += popcount(lane mask).
- Counter: saturates at all-ones; never wraps.
- First error:
  - captured on the first word with a nonzero mask; o_first_err_vld then sets and the fields freeze.
  - A word with a nonzero mask always asserts o_mism_pulse.
- o_done rises exactly when the last pipelined result has been accumulated.

Test Plan:
- 4 identical words, mode 0 (DATA_W=128) -> o_done after 4 handshakes + 2 cycles; count=0; first_err_vld=0.
- mode 0, word 2 differs in lanes 0 and 5 -> count=1; first_err_idx=2; lanes=8'b0010_0001; one mism pulse.
- mode 1, tol=2:
  - exp 0x3C00 vs acq 0x3C02 passes.
  - 0x3C00 vs 0x3C03 fails.
  - 0x0000 vs 0x8000 passes.
  - 0x7C00 vs 0x7BFF fails.
  - Expected count=2.
- Stall and backpressure:
  - random independent valid gaps on both streams with num=16 -> exactly 16 pairs consumed, no duplicates, checked=16.
  - No handshake after done; readies stay low in DONE.
- num=0 -> done within 2 cycles, count=0.
- Reset asserted mid-RUN -> all outputs 0 immediately.
- Restart with num=1 -> correct fresh result.
- Saturation: CNT_W=4, mode 1, 3 words with all 8 lanes failing -> count=15, not 8.
